// File: rtl/regfile_mp_sweepclr.sv
// Two-read / two-write register file with optional hardwired zero entry, write-to-read
// bypass, an addressed debug read port and a one-entry-per-cycle clear sweep.
module regfile_mp_sweepclr #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    output logic            busy,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   raddr0,
    output logic [XLEN-1:0] rdata0,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int NREGS = 2 ** AW;
    localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   ptr_reg, ptr_next;
    logic [XLEN-1:0] mem [NREGS];

    logic            can_write;
    logic            wr_en0, wr_en1;
    logic [AW-1:0]   raddr_arr [2];
    logic [XLEN-1:0] rdata_arr [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign busy = (state_reg == CLEAR);

    // A write is effective only when it will really land in the array this edge;
    // the bypass path keys off the same qualified enables.
    assign can_write = (state_reg == IDLE) && !clr_req && !rst;
    assign wr_en0    = can_write && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr_en1    = can_write && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem[ptr_reg] <= '0;
            end else begin
                if (wr_en0) mem[waddr0] <= wdata0;
                if (wr_en1) mem[waddr1] <= wdata1;
            end
        end
    end

    assign raddr_arr[0] = raddr0;
    assign raddr_arr[1] = raddr1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [XLEN-1:0] rd_val;
            always_comb begin
                rd_val = mem[raddr_arr[gi]];
                if (busy || ((ZERO_REG != 0) && (raddr_arr[gi] == '0))) begin
                    rd_val = '0;
                end else if ((BYPASS != 0) && wr_en1 && (waddr1 == raddr_arr[gi])) begin
                    rd_val = wdata1;
                end else if ((BYPASS != 0) && wr_en0 && (waddr0 == raddr_arr[gi])) begin
                    rd_val = wdata0;
                end
            end
            assign rdata_arr[gi] = rd_val;
        end
    endgenerate

    assign rdata0 = rdata_arr[0];
    assign rdata1 = rdata_arr[1];

    always_comb begin
        dbg_data = mem[dbg_addr];
        if (busy || ((ZERO_REG != 0) && (dbg_addr == '0))) dbg_data = '0;
    end

endmodule
